// File: rtl/smpte274_src_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : smpte274_src_ctrl                                             |
// | Purpose  : Source controller in front of the SMPTE274 timing core.       |
// |            Answers each DATA_RQ_i cycle with a Y/C word taken from an    |
// |            upstream valid/ready stream aligned on s_sof, or from an      |
// |            internal 8-bar pattern. Blanks on underflow or misalignment   |
// |            and changes source only at a vertical-blanking start.         |
// | Ports    : CLK_74M/RST      pixel clock, sync active-low reset           |
// |            EN, cfg_src      enable, source select (0 stream, 1 pattern)  |
// |            DATA_RQ_i        core word request                            |
// |            VSYNC_i          core vertical blanking flag                  |
// |            s_valid/s_sof/s_data_Y/s_data_C/s_ready  upstream stream      |
// |            o_data_Y/o_data_C  registered words to the core               |
// |            o_state          FSM state code                               |
// |            o_err_cnt/o_err  saturating error count, sticky error flag    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module smpte274_src_ctrl #(
  parameter int            DW      = 10,
  parameter logic [DW-1:0] BLANK_Y = 10'h040,
  parameter logic [DW-1:0] BLANK_C = 10'h200,
  parameter int            ERR_W   = 16
) (
  input  logic             CLK_74M,
  input  logic             RST,
  input  logic             EN,
  input  logic             cfg_src,
  input  logic             DATA_RQ_i,
  input  logic             VSYNC_i,
  input  logic             s_valid,
  input  logic             s_sof,
  input  logic [DW-1:0]    s_data_Y,
  input  logic [DW-1:0]    s_data_C,
  output logic             s_ready,
  output logic [DW-1:0]    o_data_Y,
  output logic [DW-1:0]    o_data_C,
  output logic [2:0]       o_state,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic             o_err
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_WAIT_SOF = 3'd1;
  localparam logic [2:0] c_ARMED    = 3'd2;
  localparam logic [2:0] c_STREAM   = 3'd3;
  localparam logic [2:0] c_FALLBACK = 3'd4;
  localparam logic [2:0] c_PATTERN  = 3'd5;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [2:0]       w_frame_state;
  logic             r_vs_q;
  logic             r_rq_q;
  logic             r_first_pix;
  logic [10:0]      r_pix;
  logic [ERR_W-1:0] r_err_cnt;
  logic             r_err;
  logic [DW-1:0]    r_data_y;
  logic [DW-1:0]    r_data_c;
  logic [DW-1:0]    w_y_nxt;
  logic [DW-1:0]    w_c_nxt;
  logic [DW-1:0]    w_pat_y;
  logic             w_vs_rise;
  logic             w_vs_fall;
  logic             w_in_stream;
  logic             w_sof_ok;
  logic             w_xfer;
  logic             w_err_ev;
  logic             w_ready;

  assign w_vs_rise   = VSYNC_i & ~r_vs_q;
  assign w_vs_fall   = ~VSYNC_i & r_vs_q;
  assign w_in_stream = (r_state == c_STREAM);
  // A word is acceptable only if its SOF flag agrees with "first pixel of frame".
  assign w_sof_ok    = s_valid & (s_sof == r_first_pix);
  assign w_xfer      = w_in_stream & DATA_RQ_i & w_sof_ok;
  // Covers both underflow (no word) and misalignment (SOF flag disagrees).
  assign w_err_ev    = w_in_stream & DATA_RQ_i & ~w_sof_ok;

  // The source is captured straight into the state at each frame start, so
  // the state itself remembers which source is active.
  assign w_frame_state = cfg_src ? c_PATTERN : c_WAIT_SOF;

  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      // Drain anything ahead of the SOF word; hold the SOF word itself.
      c_WAIT_SOF: w_ready = ~(s_valid & s_sof);
      // A misaligned word is left in place for the next realignment.
      c_STREAM:   w_ready = DATA_RQ_i & ~(s_valid & (s_sof != r_first_pix));
      default:    w_ready = 1'b0;
    endcase
  end

  assign s_ready = RST & w_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (!EN) begin
      w_state_nxt = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE:     if (w_vs_rise) w_state_nxt = w_frame_state;
        c_WAIT_SOF: if (s_valid & s_sof) w_state_nxt = c_ARMED;
        c_ARMED:    if (w_vs_fall) w_state_nxt = c_STREAM;
        c_STREAM: begin
          if (w_vs_rise)     w_state_nxt = w_frame_state;
          else if (w_err_ev) w_state_nxt = c_FALLBACK;
        end
        c_FALLBACK: if (w_vs_rise) w_state_nxt = w_frame_state;
        c_PATTERN:  if (w_vs_rise) w_state_nxt = w_frame_state;
        default:    w_state_nxt = c_IDLE;
      endcase
    end
  end

  // 8 colour bars of 256 pixels each.
  always_comb begin
    w_pat_y = BLANK_Y;
    case (r_pix[10:8])
      3'd0:    w_pat_y = DW'(10'd940);
      3'd1:    w_pat_y = DW'(10'd877);
      3'd2:    w_pat_y = DW'(10'd753);
      3'd3:    w_pat_y = DW'(10'd690);
      3'd4:    w_pat_y = DW'(10'd379);
      3'd5:    w_pat_y = DW'(10'd316);
      3'd6:    w_pat_y = DW'(10'd192);
      3'd7:    w_pat_y = DW'(10'd64);
      default: w_pat_y = BLANK_Y;
    endcase
  end

  always_comb begin
    w_y_nxt = BLANK_Y;
    w_c_nxt = BLANK_C;
    if (DATA_RQ_i) begin
      if (w_xfer) begin
        w_y_nxt = s_data_Y;
        w_c_nxt = s_data_C;
      end else if (r_state == c_PATTERN) begin
        w_y_nxt = w_pat_y;
        w_c_nxt = DW'(10'd512);
      end
    end
  end

  always_ff @(posedge CLK_74M) begin
    if (!RST) begin
      r_state     <= c_IDLE;
      r_vs_q      <= 1'b0;
      r_rq_q      <= 1'b0;
      r_first_pix <= 1'b0;
      r_pix       <= '0;
      r_err_cnt   <= '0;
      r_err       <= 1'b0;
      r_data_y    <= BLANK_Y;
      r_data_c    <= BLANK_C;
    end else begin
      r_state  <= w_state_nxt;
      r_vs_q   <= VSYNC_i;
      r_rq_q   <= DATA_RQ_i;
      r_data_y <= w_y_nxt;
      r_data_c <= w_c_nxt;
      // Pixel position within the current request run (one video line).
      if (DATA_RQ_i) begin
        r_pix <= r_pix + 11'd1;
      end else if (r_rq_q) begin
        r_pix <= '0;
      end
      if ((r_state == c_ARMED) && w_vs_fall) begin
        r_first_pix <= 1'b1;
      end else if (w_xfer) begin
        r_first_pix <= 1'b0;
      end
      if (w_err_ev) begin
        r_err <= 1'b1;
        if (r_err_cnt != {ERR_W{1'b1}}) begin
          r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
      end
    end
  end

  assign o_data_Y  = r_data_y;
  assign o_data_C  = r_data_c;
  assign o_state   = r_state;
  assign o_err_cnt = r_err_cnt;
  assign o_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_smpte274_src_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_smpte274_src_ctrl                                          |
// | Purpose  : Self-checking bench for smpte274_src_ctrl. Drives short video |
// |            frames with an upstream word queue and compares every cycle   |
// |            against a behavioural model of the source controller.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_smpte274_src_ctrl;

  localparam int DW      = 10;
  localparam int ERR_W   = 4;
  localparam int CNT_MAX = (1 << ERR_W) - 1;
  localparam int VB      = 48;
  localparam int HB      = 4;
  localparam logic [DW-1:0] BY = 10'h040;
  localparam logic [DW-1:0] BC = 10'h200;

  logic             CLK_74M   = 1'b0;
  logic             RST       = 1'b0;
  logic             EN        = 1'b0;
  logic             cfg_src   = 1'b0;
  logic             DATA_RQ_i = 1'b0;
  logic             VSYNC_i   = 1'b0;
  logic             s_valid   = 1'b0;
  logic             s_sof     = 1'b0;
  logic [DW-1:0]    s_data_Y  = '0;
  logic [DW-1:0]    s_data_C  = '0;
  logic             s_ready;
  logic [DW-1:0]    o_data_Y;
  logic [DW-1:0]    o_data_C;
  logic [2:0]       o_state;
  logic [ERR_W-1:0] o_err_cnt;
  logic             o_err;

  smpte274_src_ctrl #(.DW(DW), .BLANK_Y(BY), .BLANK_C(BC), .ERR_W(ERR_W)) dut (
    .CLK_74M(CLK_74M), .RST(RST), .EN(EN), .cfg_src(cfg_src),
    .DATA_RQ_i(DATA_RQ_i), .VSYNC_i(VSYNC_i), .s_valid(s_valid), .s_sof(s_sof),
    .s_data_Y(s_data_Y), .s_data_C(s_data_C), .s_ready(s_ready),
    .o_data_Y(o_data_Y), .o_data_C(o_data_C), .o_state(o_state),
    .o_err_cnt(o_err_cnt), .o_err(o_err)
  );

  always #5 CLK_74M = ~CLK_74M;

  typedef struct packed {
    logic          sof;
    logic [DW-1:0] y;
    logic [DW-1:0] c;
  } word_t;

  word_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: mode uses the state codes visible on o_state.
  int            m_mode = 0;
  logic [DW-1:0] m_y    = BY;
  logic [DW-1:0] m_c    = BC;
  int            m_cnt  = 0;
  bit            m_err  = 0;
  bit            m_vs   = 0;
  bit            m_first = 0;
  int            m_run  = 0;
  bit            m_live = 0;
  int            ytab [8] = '{940, 877, 753, 690, 379, 316, 192, 64};

  logic [DW-1:0] cap_y [0:2047];
  logic [DW-1:0] cap_c [0:2047];
  int cur_pix  = -1;
  int prev_pix = -1;
  int q_at_fall;
  logic [2:0] st_vb1;
  logic [2:0] en_state;
  logic       en_ready;
  logic [DW-1:0] en_y;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    if (!RST) return 1'b0;
    case (m_mode)
      1:       return !(s_valid && s_sof);
      3:       return DATA_RQ_i && !(s_valid && (s_sof != m_first));
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    bit rise, fall, ok, ev;
    int nxt, frame_mode;
    if (!RST) begin
      m_mode = 0; m_y = BY; m_c = BC; m_cnt = 0; m_err = 0;
      m_vs = 0; m_first = 0; m_run = 0; m_live = 1;
    end else begin
      rise = VSYNC_i && !m_vs;
      fall = !VSYNC_i && m_vs;
      ok   = s_valid && (s_sof == m_first);
      ev   = (m_mode == 3) && DATA_RQ_i && !ok;
      frame_mode = cfg_src ? 5 : 1;
      if (DATA_RQ_i && m_mode == 3 && ok) begin
        m_y = s_data_Y; m_c = s_data_C;
      end else if (DATA_RQ_i && m_mode == 5) begin
        m_y = DW'(ytab[m_run / 256]); m_c = DW'(512);
      end else begin
        m_y = BY; m_c = BC;
      end
      if (m_mode == 2 && fall) m_first = 1;
      else if (m_mode == 3 && DATA_RQ_i && ok) m_first = 0;
      m_run = DATA_RQ_i ? (m_run + 1) % 2048 : 0;
      nxt = m_mode;
      if (!EN) nxt = 0;
      else begin
        case (m_mode)
          0: if (rise) nxt = frame_mode;
          1: if (s_valid && s_sof) nxt = 2;
          2: if (fall) nxt = 3;
          3: if (rise) nxt = frame_mode; else if (ev) nxt = 4;
          default: if (rise) nxt = frame_mode;
        endcase
      end
      m_mode = nxt;
      if (ev) begin
        m_err = 1;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
      m_vs = VSYNC_i;
    end
  endtask

  task automatic cycle();
    bit hs;
    @(negedge CLK_74M);
    if (m_live) begin
      chk("s_ready",   s_ready,   exp_ready());
      chk("o_data_Y",  o_data_Y,  m_y);
      chk("o_data_C",  o_data_C,  m_c);
      chk("o_state",   o_state,   m_mode);
      chk("o_err_cnt", o_err_cnt, m_cnt);
      chk("o_err",     o_err,     m_err);
    end
    if (prev_pix >= 0) begin
      cap_y[prev_pix] = o_data_Y;
      cap_c[prev_pix] = o_data_C;
    end
    prev_pix = cur_pix;
    hs = s_valid && s_ready;
    model_step();
    @(posedge CLK_74M); #1;
    if (hs && q.size() > 0) void'(q.pop_front());
  endtask

  task automatic drive_up(input bit gaps, input bit drop);
    if (q.size() > 0 && !drop && !(gaps && !DATA_RQ_i && $urandom_range(3) == 0)) begin
      s_valid = 1'b1; s_sof = q[0].sof; s_data_Y = q[0].y; s_data_C = q[0].c;
    end else begin
      s_valid = 1'b0; s_sof = 1'($urandom_range(1));
      s_data_Y = DW'($urandom); s_data_C = DW'($urandom);
    end
  endtask

  task automatic push_word(input bit sof, input int y, input int c);
    word_t w;
    w.sof = sof; w.y = DW'(y); w.c = DW'(c);
    q.push_back(w);
  endtask

  task automatic run_frame(input int lines, input int ppl, input int junk,
                           input int drop_at, input int mis_at, input int flip_at,
                           input bit flip_val, input int en_at, input int rst_at,
                           input bit push, input bit flush, input bit gaps, input int y0);
    int k;
    if (flush) q.delete();
    if (push && q.size() < 80) begin
      for (int j = 0; j < junk; j++) push_word(1'b0, 'h3A0 + j, 'h0F0 + j);
      for (int i = 0; i < lines * ppl; i++) push_word(i == 0 || i == mis_at, y0 + i, 'h300 + i);
    end
    VSYNC_i = 1'b1; DATA_RQ_i = 1'b0;
    for (int v = 0; v < VB; v++) begin
      if (v == 1) st_vb1 = o_state;
      drive_up(gaps, 1'b0); cur_pix = -1; cycle();
    end
    q_at_fall = q.size();
    VSYNC_i = 1'b0;
    for (int l = 0; l < lines; l++) begin
      for (int h = 0; h < HB; h++) begin
        DATA_RQ_i = 1'b0;
        if (l == en_at && h == 0) EN = 1'b0;
        if (l == en_at && h == 3) EN = 1'b1;
        if (l == en_at && h == 1) begin
          en_state = o_state; en_ready = s_ready; en_y = o_data_Y;
        end
        if (l == rst_at && h == 0) RST = 1'b0;
        if (l == rst_at && h == 2) RST = 1'b1;
        drive_up(gaps, 1'b0); cur_pix = -1; cycle();
      end
      for (int p = 0; p < ppl; p++) begin
        k = l * ppl + p;
        DATA_RQ_i = 1'b1;
        if (k == flip_at) cfg_src = flip_val;
        drive_up(gaps, k == drop_at);
        cur_pix = k; cycle();
      end
    end
    DATA_RQ_i = 1'b0;
    for (int t = 0; t < 4; t++) begin
      drive_up(gaps, 1'b0); cur_pix = -1; cycle();
    end
  endtask

  task automatic random_frame();
    int ppl, n, drop, mis, flip, en, rs;
    bit fv;
    ppl  = $urandom_range(16, 8);
    n    = 2 * ppl;
    drop = ($urandom_range(1) == 0) ? $urandom_range(n - 1) : -1;
    mis  = ($urandom_range(2) == 0) ? $urandom_range(n - 1, 1) : -1;
    flip = ($urandom_range(1) == 0) ? $urandom_range(n - 1) : -1;
    fv   = ($urandom_range(3) == 0);
    en   = ($urandom_range(9) == 0) ? 1 : -1;
    rs   = (en < 0 && $urandom_range(14) == 0) ? 0 : -1;
    run_frame(2, ppl, $urandom_range(3), drop, mis, flip, fv, en, rs,
              1'b1, 1'b0, 1'b1, $urandom_range(1023));
  endtask

  initial begin
    RST = 1'b0; EN = 1'b1;
    @(posedge CLK_74M); #1;
    repeat (4) begin drive_up(1'b0, 1'b0); cur_pix = -1; cycle(); end
    RST = 1'b1;
    repeat (3) begin drive_up(1'b0, 1'b0); cur_pix = -1; cycle(); end
    chk("reset_y",     o_data_Y, 32'h040);
    chk("reset_c",     o_data_C, 32'h200);
    chk("reset_ready", s_ready,  32'h0);
    chk("reset_state", o_state,  32'h0);
    chk("reset_cnt",   o_err_cnt, 32'h0);
    chk("reset_err",   o_err,    32'h0);

    // Aligned stream: 3 junk words then SOF word 0x111 and a ramp.
    run_frame(2, 12, 3, -1, -1, -1, 1'b0, -1, -1, 1'b1, 1'b1, 1'b0, 'h111);
    chk("junk_consumed", q_at_fall, 32'd24);
    chk("first_y",       cap_y[0],  32'h111);
    chk("first_c",       cap_c[0],  32'h300);
    chk("last_y",        cap_y[23], 32'h128);
    chk("all_consumed",  q.size(),  32'd0);
    chk("aligned_state", o_state,   32'd3);

    // Underflow at pixel 5.
    run_frame(2, 12, 0, 5, -1, -1, 1'b0, -1, -1, 1'b1, 1'b1, 1'b0, 'h050);
    chk("uf_before",   cap_y[4],  32'h054);
    chk("uf_blank",    cap_y[5],  32'h040);
    chk("uf_persist",  cap_y[10], 32'h040);
    chk("uf_cnt",      o_err_cnt, 32'd1);
    chk("uf_err",      o_err,     32'd1);
    chk("uf_state",    o_state,   32'd4);

    // Misalignment: extra SOF on the 10th pixel.
    run_frame(2, 12, 0, -1, 9, -1, 1'b0, -1, -1, 1'b1, 1'b1, 1'b0, 'h180);
    chk("realign_state", st_vb1,   32'd1);
    chk("mis_before",    cap_y[8], 32'h188);
    chk("mis_blank",     cap_y[9], 32'h040);
    chk("mis_cnt",       o_err_cnt, 32'd2);
    chk("mis_state",     o_state,  32'd4);
    chk("mis_held",      q.size(), 32'd15);

    // cfg_src flipped mid-frame has no effect until the next frame start.
    run_frame(2, 12, 1, -1, -1, 6, 1'b1, -1, -1, 1'b1, 1'b1, 1'b0, 'h200);
    chk("flip_stream_y", cap_y[20], 32'h214);
    chk("flip_state",    o_state,   32'd3);

    // Pattern frame with one 2048-pixel line.
    run_frame(1, 2048, 0, -1, -1, -1, 1'b0, -1, -1, 1'b0, 1'b1, 1'b0, 0);
    chk("pat_state0", st_vb1,      32'd5);
    chk("pat_y0",     cap_y[0],    32'd940);
    chk("pat_y255",   cap_y[255],  32'd940);
    chk("pat_y256",   cap_y[256],  32'd877);
    chk("pat_y1792",  cap_y[1792], 32'd64);
    chk("pat_y2047",  cap_y[2047], 32'd64);
    chk("pat_c1000",  cap_c[1000], 32'd512);
    chk("pat_state",  o_state,     32'd5);

    // EN drop in the hblank before line 1 of a streaming frame.
    cfg_src = 1'b0;
    run_frame(3, 12, 0, -1, -1, -1, 1'b0, 1, -1, 1'b1, 1'b1, 1'b0, 'h300);
    chk("en_line0_y",  cap_y[0],  32'h300);
    chk("en_state",    en_state,  32'd0);
    chk("en_ready",    en_ready,  32'd0);
    chk("en_blank",    en_y,      32'h040);
    chk("en_line1_y",  cap_y[12], 32'h040);
    chk("en_cnt_hold", o_err_cnt, 32'd2);
    chk("en_idle",     o_state,   32'd0);

    for (int f = 0; f < 60; f++) random_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
